// File: rtl/full_adder_fa_cell.sv
// rtl/full_adder_fa_cell.sv - combinational 1-bit full adder cell
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered ripple-carry adder built from fa_cell
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears s and cout
//   a, b : WIDTH-bit unsigned operands
//   cin  : carry into bit 0
//   s    : registered (a + b + cin) mod 2^WIDTH
//   cout : registered bit WIDTH of (a + b + cin)
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = cin;

  // Plain ripple chain: each cell's carry out feeds the next cell's carry in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      cout <= c[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - self-checking bench for full_adder at WIDTH 1 and 4
module tb_full_adder;

  logic       clk;
  logic       rst;
  logic       a1, b1, cin1;
  logic       s1, cout1;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] s4;
  logic       cout4;

  int n_cmp = 0;
  int n_err = 0;

  // Reference results: what each adder should currently show.
  logic [1:0] exp1;
  logic [4:0] exp4;

  full_adder #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .s    (s1),
    .cout (cout1)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .a    (a4),
    .b    (b4),
    .cin  (cin4),
    .s    (s4),
    .cout (cout4)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp1 <= 2'd0;
      exp4 <= 5'd0;
    end else begin
      exp1 <= 2'(a1) + 2'(b1) + 2'(cin1);
      exp4 <= 5'(a4) + 5'(b4) + 5'(cin4);
    end
  end

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst  = 1'b1;
    a1   = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a4   = 4'd15; b4 = 4'd15; cin4 = 1'b1;

    // Reset holds outputs low before and across a clock edge.
    #2;
    check("reset_pre_edge_w1", 5'({cout1, s1}), 5'd0);
    check("reset_pre_edge_w4", {cout4, s4}, 5'd0);
    @(posedge clk); #1;
    check("reset_across_edge_w1", 5'({cout1, s1}), 5'd0);
    check("reset_across_edge_w4", {cout4, s4}, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_w1", 5'({cout1, s1}), 5'b00011);
    check("release_full_scale_w4", {cout4, s4}, 5'b11111);

    // Exhaustive truth table of the 1-bit cell.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      {a1, b1, cin1} = 3'(k);
      @(posedge clk); #1;
      check($sformatf("truth_%0d%0d%0d", k[2], k[1], k[0]), 5'({cout1, s1}), 5'(exp1));
      check($sformatf("truth_popcount_%0d", k), 5'({cout1, s1}), 5'($countones(3'(k))));
    end

    // Latency: a change just after an edge is invisible until the next edge.
    @(negedge clk);
    {a1, b1, cin1} = 3'b000;
    @(posedge clk); #1;
    {a1, b1, cin1} = 3'b011;
    #5;
    check("latency_hold_early", 5'({cout1, s1}), 5'b00000);
    @(negedge clk);
    check("latency_hold_negedge", 5'({cout1, s1}), 5'b00000);
    @(posedge clk); #1;
    check("latency_update", 5'({cout1, s1}), 5'b00010);

    // Fast stimulus: inputs step every 10 ns against a 30 ns clock.
    #4;
    for (int k = 0; k < 8; k++) begin
      {a1, b1, cin1} = 3'(k);
      #4;
      check($sformatf("fast_step%0d_a", k), 5'({cout1, s1}), 5'(exp1));
      #3;
      check($sformatf("fast_step%0d_b", k), 5'({cout1, s1}), 5'(exp1));
      #3;
    end
    @(posedge clk); #1;
    check("fast_final", 5'({cout1, s1}), 5'b00011);

    // Short asynchronous reset pulse between edges.
    @(negedge clk);
    {a1, b1, cin1} = 3'b111;
    @(posedge clk); #1;
    check("pulse_before", 5'({cout1, s1}), 5'b00011);
    #4;
    rst = 1'b1;
    #1;
    check("pulse_during_w1", 5'({cout1, s1}), 5'd0);
    check("pulse_during_w4", {cout4, s4}, 5'd0);
    #2;
    rst = 1'b0;
    #1;
    check("pulse_after_release", 5'({cout1, s1}), 5'd0);
    #5;
    check("pulse_before_edge", 5'({cout1, s1}), 5'd0);
    @(posedge clk); #1;
    check("pulse_recover", 5'({cout1, s1}), 5'b00011);

    // WIDTH = 4 directed corner cases.
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1;
    @(posedge clk); #1;
    check("w4_15_15_1", {cout4, s4}, 5'b11111);
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd6; cin4 = 1'b0;
    @(posedge clk); #1;
    check("w4_9_6_0", {cout4, s4}, 5'b01111);
    @(negedge clk);
    a4 = 4'd8; b4 = 4'd8; cin4 = 1'b0;
    @(posedge clk); #1;
    check("w4_8_8_0", {cout4, s4}, 5'b10000);

    // Random operands on both widths.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      {a1, b1, cin1} = 3'($urandom_range(0, 7));
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check($sformatf("rand_w1_%0d", k), 5'({cout1, s1}), 5'(exp1));
      check($sformatf("rand_w4_%0d", k), {cout4, s4}, exp4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
